// File: rtl/uart_rx_ctrl.sv
// Frame-level control for the UART receiver: start detection, per-bit edge and bit
// counting, checker/sampler enables and word qualification.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int PRESCALE_BITS = 5,
  parameter int TX_BITS       = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_IN,
  input  logic                     PAR_EN,
  input  logic [PRESCALE_BITS-1:0] Prescale,
  input  logic                     strt_glitch,
  input  logic                     par_err,
  input  logic                     stp_err,
  output logic [PRESCALE_BITS-1:0] edge_cnt,
  output logic [TX_BITS-1:0]       bit_cnt,
  output logic                     dat_samp_en,
  output logic                     deser_en,
  output logic                     strt_chk_en,
  output logic                     par_chk_en,
  output logic                     stp_chk_en,
  output logic                     data_valid,
  output logic                     frame_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [TX_BITS-1:0]       LAST_DATA_BIT = TX_BITS'(DATA_WIDTH);
  localparam logic [PRESCALE_BITS-1:0] EDGE_ONE      = PRESCALE_BITS'(1);
  localparam logic [TX_BITS-1:0]       BIT_ONE       = TX_BITS'(1);

  logic [2:0]               state_q, state_d;
  logic [PRESCALE_BITS-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
  logic [TX_BITS-1:0]       bit_cnt_q, bit_cnt_d;
  logic                     bit_end_s;
  logic                     frame_ok_s;
  logic                     frame_bad_s;

  // Timing uses the Prescale captured at frame start, never the live input
  assign bit_end_s = (edge_cnt_q == (prescale_q - EDGE_ONE));

  // Next-state decode plus the end-of-frame result pulses
  always_comb begin
    state_d     = state_q;
    frame_ok_s  = 1'b0;
    frame_bad_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          if (strt_glitch) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_q == LAST_DATA_BIT)) begin
          if (PAR_EN) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_STOP;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          if (par_err) begin
            state_d     = ST_IDLE;
            frame_bad_s = 1'b1;
          end else begin
            state_d = ST_STOP;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_d = ST_IDLE;
          if (stp_err) begin
            frame_bad_s = 1'b1;
          end else begin
            frame_ok_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Edge/bit counters; cleared whenever the frame is idle or just ending
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      edge_cnt_d = {PRESCALE_BITS{1'b0}};
      bit_cnt_d  = {TX_BITS{1'b0}};
    end else if (bit_end_s) begin
      edge_cnt_d = {PRESCALE_BITS{1'b0}};
      bit_cnt_d  = bit_cnt_q + BIT_ONE;
    end else begin
      edge_cnt_d = edge_cnt_q + EDGE_ONE;
      bit_cnt_d  = bit_cnt_q;
    end
  end

  // Capture Prescale only on the start edge
  always_comb begin
    if ((state_q == ST_IDLE) && !RX_IN) begin
      prescale_d = Prescale;
    end else begin
      prescale_d = prescale_q;
    end
  end

  // State and counter registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= {PRESCALE_BITS{1'b0}};
      bit_cnt_q  <= {TX_BITS{1'b0}};
      prescale_q <= {PRESCALE_BITS{1'b0}};
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      prescale_q <= prescale_d;
    end
  end

  // Moore enables decoded straight from the state register
  always_comb begin
    dat_samp_en = 1'b1;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (state_q)
      ST_IDLE:   dat_samp_en = 1'b0;
      ST_START:  strt_chk_en = 1'b1;
      ST_DATA:   deser_en    = 1'b1;
      ST_PARITY: par_chk_en  = 1'b1;
      ST_STOP:   stp_chk_en  = 1'b1;
      default:   dat_samp_en = 1'b0;
    endcase
  end

  assign edge_cnt   = edge_cnt_q;
  assign bit_cnt    = bit_cnt_q;
  // Mealy pulses fire in the final bit cycle so the word is still held downstream
  assign data_valid = frame_ok_s;
  assign frame_err  = frame_bad_s;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit by bit, expected result
// pulses (kind and cycle) are queued at start detection and matched by a monitor.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PB = 5;
  localparam int TB = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic [PB-1:0] Prescale = 5'd8;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic [PB-1:0] edge_cnt;
  logic [TB-1:0] bit_cnt;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic          data_valid, frame_err;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_BITS(PB), .TX_BITS(TB)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] kind;   // 2'b10 data_valid, 2'b01 frame_err
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pulse_cnt = 0, deser_cnt = 0, par_cnt = 0, stp_cnt = 0, max_bit = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: per-frame activity statistics and scoreboard matching of result pulses
  always @(negedge CLK) begin
    if (deser_en) deser_cnt++;
    if (par_chk_en) par_cnt++;
    if (stp_chk_en) stp_cnt++;
    if (int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
    if (data_valid || frame_err) begin
      pulse_cnt++;
      check_val("pulse_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_val("pulse_kind", {30'd0, data_valid, frame_err}, {30'd0, mon_e.kind});
        check_val("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic send_frame(input logic [7:0] data, input int presc, input logic par_en,
                            input logic glitch, input logic perr, input logic serr,
                            input int presc_mid);
    int          nb;
    exp_t        e;
    logic [10:0] bits;
    bits      = {1'b1, (par_en ? ^data : 1'b1), data, 1'b0};
    if (serr) begin
      if (par_en) bits[10] = 1'b0;
      else        bits[9]  = 1'b0;
    end
    nb        = glitch ? 1 : (perr ? 10 : (par_en ? 11 : 10));
    pulse_cnt = 0; deser_cnt = 0; par_cnt = 0; stp_cnt = 0; max_bit = 0;
    Prescale    = PB'(presc);
    PAR_EN      = par_en;
    strt_glitch = glitch;
    par_err     = perr;
    stp_err     = serr;
    RX_IN       = 1'b0;
    @(posedge CLK); #1;
    if (!glitch) begin
      e.kind = (perr || serr) ? 2'b01 : 2'b10;
      e.cyc  = cyc + nb * presc - 1;
      sb.push_back(e);
    end
    for (int b = 0; b < nb; b++) begin
      if (glitch) begin
        @(posedge CLK); #1;
        RX_IN = 1'b1;
        repeat (presc - 1) @(posedge CLK);
        #1;
      end else begin
        RX_IN = bits[b];
        if (b == 4 && presc_mid != 0) Prescale = PB'(presc_mid);
        repeat (presc) @(posedge CLK);
        #1;
      end
    end
    RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    check_val("pulse_count", pulse_cnt, glitch ? 32'd0 : 32'd1);
    check_val("deser_cycles", deser_cnt, glitch ? 32'd0 : 32'(DW * presc));
    check_val("par_chk_cycles", par_cnt, (par_en && !glitch) ? 32'(presc) : 32'd0);
    check_val("stp_chk_cycles", stp_cnt, (glitch || perr) ? 32'd0 : 32'(presc));
    check_val("max_bit_cnt", max_bit, glitch ? 32'd0 : (perr ? 32'd9 : (par_en ? 32'd10 : 32'd9)));
    check_val("idle_after_frame", {22'd0, dat_samp_en, bit_cnt, edge_cnt}, 32'd0);
    check_val("scoreboard_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_edge_cnt", {27'd0, edge_cnt}, 32'd0);
    check_val("rst_bit_cnt", {28'd0, bit_cnt}, 32'd0);
    check_val("rst_enables", {27'd0, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en}, 32'd0);
    check_val("rst_pulses", {30'd0, data_valid, frame_err}, 32'd0);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // parity frame, 88-cycle result
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 0);  // no parity
    send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 0);   // start glitch
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b0, 0);   // parity error
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b1, 0);   // stop error
    send_frame(8'hC3, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);   // minimum prescale
    send_frame(8'h96, 31, 1'b1, 1'b0, 1'b0, 1'b0, 0);  // maximum prescale

    // reset in the middle of a data bit
    pulse_cnt = 0;
    Prescale = 5'd8; PAR_EN = 1'b1; RX_IN = 1'b0;
    @(posedge CLK); #1;
    RX_IN = 1'b1;
    for (int g = 0; g < 200 && bit_cnt != 4'd4; g++) @(negedge CLK);
    check_val("rst_wait_bitcnt", {28'd0, bit_cnt}, 32'd4);
    check_val("rst_pre_deser", {31'd0, deser_en}, 32'd1);
    #2 RST = 1'b0;
    #1;
    check_val("rst_async_cnt", {23'd0, edge_cnt, bit_cnt}, 32'd0);
    check_val("rst_async_out", {25'd0, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                                stp_chk_en, data_valid, frame_err}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_no_pulse", pulse_cnt, 32'd0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    send_frame(8'h77, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // back-to-back, Prescale changed mid-frame 1
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b0, 16);
    send_frame(8'hFF, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // a few random frames
    for (int r = 0; r < 4; r++) begin
      send_frame(8'($urandom_range(255, 0)), int'($urandom_range(31, 4)),
                 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
